// File: rtl/rf_wb_arbiter_if.sv
// Bundle of the WB-arbiter signals: pipeline writeback, long-latency results,
// decode busy lookups and the register file write port.
interface rf_wb_arbiter_if #(
   parameter int DATA_W = 32
);
   logic              pipe_wr;
   logic [4:0]        pipe_addr;
   logic [DATA_W-1:0] pipe_data;
   logic              lu_issue;
   logic [4:0]        lu_issue_addr;
   logic              lu_done_valid;
   logic              lu_done_ready;
   logic [4:0]        lu_done_addr;
   logic [DATA_W-1:0] lu_done_data;
   logic [4:0]        rd_addr1;
   logic [4:0]        rd_addr2;
   logic              busy1;
   logic              busy2;
   logic              issue_conflict;
   logic              rf_wr;
   logic [4:0]        rf_addr;
   logic [DATA_W-1:0] rf_data;
   logic              pipe_stall;

   modport master (
      output pipe_wr, pipe_addr, pipe_data, lu_issue, lu_issue_addr,
             lu_done_valid, lu_done_addr, lu_done_data, rd_addr1, rd_addr2,
      input  lu_done_ready, busy1, busy2, issue_conflict, rf_wr, rf_addr,
             rf_data, pipe_stall
   );

   modport slave (
      input  pipe_wr, pipe_addr, pipe_data, lu_issue, lu_issue_addr,
             lu_done_valid, lu_done_addr, lu_done_data, rd_addr1, rd_addr2,
      output lu_done_ready, busy1, busy2, issue_conflict, rf_wr, rf_addr,
             rf_data, pipe_stall
   );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback vs. buffered long-latency results,
// plus pending-destination scoreboard. Define RF_WB_STARVE_GUARD_EN for the starvation guard.
module rf_wb_arbiter #(
   parameter int FIFO_DEPTH   = 4,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 8
) (
   input logic            clk,
   input logic            reset,
   rf_wb_arbiter_if.slave bus
);
   localparam int PW = $clog2(FIFO_DEPTH);

   logic [4:0]        fifo_addr [FIFO_DEPTH];
   logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
   logic [PW-1:0]     rd_ptr, wr_ptr;
   logic [PW:0]       count;
   logic [31:1]       pending, pend_next;
   logic [31:0]       pend_vec;
   logic              empty, full, push, pop, pipe_go, pipe_win, starve;
   logic [4:0]        head_addr;
   logic [DATA_W-1:0] head_data;

   assign empty             = (count == '0);
   assign full              = (count == (PW+1)'(FIFO_DEPTH));
   // Ready looks at occupancy only; a pop in the same cycle does not free a slot.
   assign bus.lu_done_ready = !full;
   assign push              = bus.lu_done_valid && !full;
   assign head_addr         = fifo_addr[rd_ptr];
   assign head_data         = fifo_data[rd_ptr];
   assign pipe_go           = bus.pipe_wr && (bus.pipe_addr != 5'd0);

`ifdef RF_WB_STARVE_GUARD_EN
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   logic [SW-1:0] starve_cnt;

   assign starve = !empty && (starve_cnt == SW'(STARVE_LIMIT));

   // Any cycle with a non-empty FIFO that does not pop is a cycle the pipeline won.
   always_ff @(posedge clk or posedge reset)
      if (reset)              starve_cnt <= '0;
      else if (pop || empty)  starve_cnt <= '0;
      else                    starve_cnt <= starve_cnt + SW'(1);
`else
   // Never true: without the guard the pipeline always has priority.
   assign starve = (STARVE_LIMIT < 0);
`endif

   assign bus.pipe_stall = starve;
   assign pipe_win       = pipe_go && !starve;
   assign pop            = !empty && !pipe_win;

   // Bit 0 is hard zero so r0 never reads busy.
   assign pend_vec           = {pending, 1'b0};
   assign bus.busy1          = pend_vec[bus.rd_addr1];
   assign bus.busy2          = pend_vec[bus.rd_addr2];
   assign bus.issue_conflict = bus.lu_issue && pend_vec[bus.lu_issue_addr];

   // Set beats clear when an issue and a retiring pop hit the same register.
   always_comb begin
      pend_next = '0;
      for (int i = 1; i < 32; i++)
         pend_next[i] = (bus.lu_issue && (bus.lu_issue_addr == 5'(i))) ||
                        (pending[i] && !(pop && (head_addr == 5'(i))));
   end

   always_ff @(posedge clk)
      if (push) begin
         fifo_addr[wr_ptr] <= bus.lu_done_addr;
         fifo_data[wr_ptr] <= bus.lu_done_data;
      end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
         pending     <= '0;
         bus.rf_wr   <= 1'b0;
         bus.rf_addr <= '0;
         bus.rf_data <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         if (push && !pop)      count <= count + (PW+1)'(1);
         else if (pop && !push) count <= count - (PW+1)'(1);
         pending   <= pend_next;
         bus.rf_wr <= 1'b0;
         if (pipe_win) begin
            bus.rf_wr   <= 1'b1;
            bus.rf_addr <= bus.pipe_addr;
            bus.rf_data <= bus.pipe_data;
         end else if (pop) begin
            // An r0 result still drains, but never raises the write enable.
            bus.rf_wr   <= (head_addr != 5'd0);
            bus.rf_addr <= head_addr;
            bus.rf_data <= head_data;
         end
      end
   end
endmodule
